// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game controller: FSM state encoding,
// mode LED codes and the pattern legality rule.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_INPUT    = 2'd0,
        ST_PLAYBACK = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
    localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
    localparam logic [2:0] LED_MODE_DONE     = 3'b111;

    // Callers zero-extend their pattern to 32 bits; a single set bit is p & (p-1) == 0.
    function automatic logic pattern_legal(input logic [31:0] pat, input logic onehotOnly);
        logic nonZero;
        logic singleBit;
        nonZero   = (pat != 32'd0);
        singleBit = ((pat & (pat - 32'd1)) == 32'd0);
        return nonZero && (!onehotOnly || singleBit);
    endfunction

endpackage

// File: rtl/simon_tick_counter.sv
// Modulo-N cycle counter with synchronous clear; tc_o flags the final count N-1.
module simon_tick_counter #(
    parameter int N = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == LAST);

endmodule

// File: rtl/simon_control_gen.sv
// Simon game controller: records patterns into an external register file,
// plays the sequence back, checks the player's repeat and keeps score.
module simon_control_gen
    import simon_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int DEPTH          = 64,
    parameter int AW             = $clog2(DEPTH),
    parameter int PLAY_TICKS     = 4,
    parameter int REPEAT_TIMEOUT = 0,
    parameter int ONEHOT_ONLY    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [WIDTH-1:0] pattern,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] pattern_leds,
    output logic [2:0]       mode_leds,
    output logic [AW:0]      score,
    output logic             win,
    output logic             timeout
);

    localparam logic [AW-1:0] LAST_ENTRY = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_SCORE = (AW + 1)'(DEPTH);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   lastPtr_q, lastPtr_d;
    logic [AW:0]     score_q, score_d;
    logic            win_q, win_d;
    logic            timeout_q, timeout_d;

    logic            legal;
    logic            match;
    logic            playTc;
    logic            repeatExpired;

    assign legal = pattern_legal(32'(pattern), ONEHOT_ONLY != 0);
    assign match = (pattern == mem_rdata);

    simon_tick_counter #(.N(PLAY_TICKS)) u_play_tick (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clear_i  (state_q != ST_PLAYBACK),
        .enable_i (1'b1),
        .tc_o     (playTc)
    );

    // The repeat timer restarts on every step so it measures the gap between presses.
    generate
        if (REPEAT_TIMEOUT > 0) begin : g_timeout
            logic repeatTc;
            simon_tick_counter #(.N(REPEAT_TIMEOUT)) u_repeat_tick (
                .clk_i    (clk),
                .rst_ni   (rst),
                .clear_i  ((state_q != ST_REPEAT) || step),
                .enable_i (1'b1),
                .tc_o     (repeatTc)
            );
            assign repeatExpired = repeatTc && (state_q == ST_REPEAT);
        end else begin : g_no_timeout
            assign repeatExpired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_INPUT;
            idx_q     <= '0;
            lastPtr_q <= '0;
            score_q   <= '0;
            win_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lastPtr_q <= lastPtr_d;
            score_q   <= score_d;
            win_q     <= win_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lastPtr_d = lastPtr_q;
        score_d   = score_q;
        win_d     = win_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_INPUT: begin
                if (step && legal) begin
                    state_d = ST_PLAYBACK;
                    idx_d   = '0;
                end
            end
            ST_PLAYBACK: begin
                if (playTc) begin
                    if (idx_q < lastPtr_q) begin
                        idx_d = idx_q + AW'(1);
                    end else begin
                        state_d = ST_REPEAT;
                        idx_d   = '0;
                    end
                end
            end
            ST_REPEAT: begin
                if (step) begin
                    if (!match) begin
                        state_d = ST_DONE;
                        win_d   = 1'b0;
                    end else if (idx_q < lastPtr_q) begin
                        idx_d = idx_q + AW'(1);
                    end else if (lastPtr_q == LAST_ENTRY) begin
                        // Memory is full: the game ends in a win instead of wrapping last.
                        state_d = ST_DONE;
                        win_d   = 1'b1;
                        score_d = FULL_SCORE;
                    end else begin
                        state_d   = ST_INPUT;
                        lastPtr_d = lastPtr_q + AW'(1);
                        score_d   = score_q + (AW + 1)'(1);
                        idx_d     = '0;
                    end
                end else if (repeatExpired) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        mode_leds    = LED_MODE_INPUT;
        pattern_leds = pattern;
        mem_addr     = idx_q;
        mem_we       = 1'b0;
        case (state_q)
            ST_INPUT: begin
                mem_addr = lastPtr_q;
                mem_we   = step && legal;
            end
            ST_PLAYBACK: begin
                mode_leds    = LED_MODE_PLAYBACK;
                pattern_leds = mem_rdata;
            end
            ST_REPEAT: begin
                mode_leds = LED_MODE_REPEAT;
            end
            default: begin
                mode_leds    = LED_MODE_DONE;
                pattern_leds = mem_rdata;
            end
        endcase
    end

    assign mem_wdata = pattern;
    assign score     = score_q;
    assign win       = win_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_simon_control_gen.sv
// Scoreboard bench for simon_control_gen: four instances (default, one-hot only,
// DEPTH=4, repeat timeout 8) each backed by its own register-file model.
module tb_simon_control_gen;

    typedef struct {
        int         dut;
        logic [2:0] mode;
        int         score;
        logic       win;
        logic       to;
        int         dur;
    } modeExp_t;

    typedef struct {
        int         dut;
        int         addr;
        logic [3:0] data;
    } wrExp_t;

    typedef struct {
        int         dut;
        logic [3:0] led;
    } ledExp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstL[4];
    logic       stepL[4];
    logic [3:0] patL[4];

    logic [2:0] modeA[4];
    logic [6:0] scoreA[4];
    logic       winA[4];
    logic       toA[4];
    logic       weA[4];
    logic [5:0] addrA[4];
    logic [3:0] ledA[4];
    logic [3:0] wdA[4];
    logic [3:0] rdA[4];
    logic [3:0] mem[4][64];

    logic [2:0] mode0, mode1, mode2, mode3;
    logic [6:0] score0, score1, score3;
    logic [2:0] score2;
    logic       win0, win1, win2, win3, to0, to1, to2, to3, we0, we1, we2, we3;
    logic [5:0] addr0, addr1, addr3;
    logic [1:0] addr2;
    logic [3:0] led0, led1, led2, led3, wd0, wd1, wd2, wd3;

    simon_control_gen #(.WIDTH(4), .DEPTH(64), .PLAY_TICKS(4), .REPEAT_TIMEOUT(0), .ONEHOT_ONLY(0)) dut0 (
        .clk(clk), .rst(rstL[0]), .step(stepL[0]), .pattern(patL[0]), .mem_we(we0), .mem_addr(addr0),
        .mem_wdata(wd0), .mem_rdata(rdA[0]), .pattern_leds(led0), .mode_leds(mode0), .score(score0),
        .win(win0), .timeout(to0));

    simon_control_gen #(.WIDTH(4), .DEPTH(64), .PLAY_TICKS(4), .REPEAT_TIMEOUT(0), .ONEHOT_ONLY(1)) dut1 (
        .clk(clk), .rst(rstL[1]), .step(stepL[1]), .pattern(patL[1]), .mem_we(we1), .mem_addr(addr1),
        .mem_wdata(wd1), .mem_rdata(rdA[1]), .pattern_leds(led1), .mode_leds(mode1), .score(score1),
        .win(win1), .timeout(to1));

    simon_control_gen #(.WIDTH(4), .DEPTH(4), .PLAY_TICKS(4), .REPEAT_TIMEOUT(0), .ONEHOT_ONLY(0)) dut2 (
        .clk(clk), .rst(rstL[2]), .step(stepL[2]), .pattern(patL[2]), .mem_we(we2), .mem_addr(addr2),
        .mem_wdata(wd2), .mem_rdata(rdA[2]), .pattern_leds(led2), .mode_leds(mode2), .score(score2),
        .win(win2), .timeout(to2));

    simon_control_gen #(.WIDTH(4), .DEPTH(64), .PLAY_TICKS(4), .REPEAT_TIMEOUT(8), .ONEHOT_ONLY(0)) dut3 (
        .clk(clk), .rst(rstL[3]), .step(stepL[3]), .pattern(patL[3]), .mem_we(we3), .mem_addr(addr3),
        .mem_wdata(wd3), .mem_rdata(rdA[3]), .pattern_leds(led3), .mode_leds(mode3), .score(score3),
        .win(win3), .timeout(to3));

    always_comb begin
        modeA[0] = mode0;  modeA[1] = mode1;  modeA[2] = mode2;  modeA[3] = mode3;
        scoreA[0] = score0; scoreA[1] = score1; scoreA[2] = {4'b0, score2}; scoreA[3] = score3;
        winA[0] = win0; winA[1] = win1; winA[2] = win2; winA[3] = win3;
        toA[0] = to0; toA[1] = to1; toA[2] = to2; toA[3] = to3;
        weA[0] = we0; weA[1] = we1; weA[2] = we2; weA[3] = we3;
        addrA[0] = addr0; addrA[1] = addr1; addrA[2] = {4'b0, addr2}; addrA[3] = addr3;
        ledA[0] = led0; ledA[1] = led1; ledA[2] = led2; ledA[3] = led3;
        wdA[0] = wd0; wdA[1] = wd1; wdA[2] = wd2; wdA[3] = wd3;
    end

    // Register-file model: asynchronous read, write on the clock edge.
    always_comb begin
        for (int k = 0; k < 4; k++) rdA[k] = mem[k][addrA[k]];
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (weA[k]) mem[k][addrA[k]] <= wdA[k];
        end
    end

    modeExp_t   modeQ[$];
    wrExp_t     wrQ[$];
    ledExp_t    ledQ[$];
    int         compared = 0;
    int         mismatched = 0;
    logic       started = 1'b0;

    logic [3:0] seqM[4][64];
    int         lastM[4];
    int         scoreM[4];

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT writes, changes mode or plays back.
    initial begin
        logic [2:0] prevMode[4];
        int         durCnt[4];
        for (int k = 0; k < 4; k++) begin
            prevMode[k] = 3'b001;
            durCnt[k]   = 0;
        end
        forever begin
            @(negedge clk);
            if (started) begin
                for (int k = 0; k < 4; k++) begin
                    if (weA[k]) begin
                        if (wrQ.size() == 0) begin
                            checkOutput($sformatf("dut%0d unexpected write", k), 1, 0);
                        end else begin
                            wrExp_t w;
                            w = wrQ.pop_front();
                            checkOutput($sformatf("dut%0d write owner", k), k, w.dut);
                            checkOutput($sformatf("dut%0d write addr", k), int'(addrA[k]), w.addr);
                            checkOutput($sformatf("dut%0d write data", k), int'(wdA[k]), int'(w.data));
                        end
                    end
                    if (modeA[k] != prevMode[k]) begin
                        if (modeQ.size() == 0) begin
                            checkOutput($sformatf("dut%0d unexpected mode", k), int'(modeA[k]), int'(prevMode[k]));
                        end else begin
                            modeExp_t m;
                            m = modeQ.pop_front();
                            checkOutput($sformatf("dut%0d mode owner", k), k, m.dut);
                            checkOutput($sformatf("dut%0d mode_leds", k), int'(modeA[k]), int'(m.mode));
                            checkOutput($sformatf("dut%0d score", k), int'(scoreA[k]), m.score);
                            checkOutput($sformatf("dut%0d win", k), int'(winA[k]), int'(m.win));
                            checkOutput($sformatf("dut%0d timeout", k), int'(toA[k]), int'(m.to));
                            if (m.dur >= 0)
                                checkOutput($sformatf("dut%0d cycles in previous mode", k), durCnt[k], m.dur);
                        end
                        prevMode[k] = modeA[k];
                        durCnt[k]   = 1;
                    end else begin
                        durCnt[k]++;
                    end
                    if (modeA[k] == 3'b010) begin
                        if (ledQ.size() == 0) begin
                            checkOutput($sformatf("dut%0d unexpected playback", k), int'(ledA[k]), 0);
                        end else begin
                            ledExp_t l;
                            l = ledQ.pop_front();
                            checkOutput($sformatf("dut%0d playback owner", k), k, l.dut);
                            checkOutput($sformatf("dut%0d playback leds", k), int'(ledA[k]), int'(l.led));
                        end
                    end else if (modeA[k] == 3'b001 || modeA[k] == 3'b100) begin
                        checkOutput($sformatf("dut%0d leds follow pattern", k), int'(ledA[k]), int'(patL[k]));
                    end
                end
            end
        end
    end

    task automatic pressStep(input int k, input logic [3:0] p);
        @(posedge clk);
        #1;
        patL[k]  = p;
        stepL[k] = 1'b1;
        @(posedge clk);
        #1;
        stepL[k] = 1'b0;
    endtask

    // Enter a new pattern and let the whole playback run out.
    task automatic applyStimulus(input int k, input logic [3:0] p);
        seqM[k][lastM[k]] = p;
        wrQ.push_back('{k, lastM[k], p});
        modeQ.push_back('{k, 3'b010, scoreM[k], 1'b0, 1'b0, -1});
        for (int e = 0; e <= lastM[k]; e++)
            for (int t = 0; t < 4; t++) ledQ.push_back('{k, seqM[k][e]});
        modeQ.push_back('{k, 3'b100, scoreM[k], 1'b0, 1'b0, (lastM[k] + 1) * 4});
        pressStep(k, p);
        repeat ((lastM[k] + 1) * 4) @(posedge clk);
        #1;
    endtask

    // Repeat the stored sequence; wrongAt >= 0 enters wrongPat at that index.
    task automatic repeatRound(input int k, input int depth, input int wrongAt, input logic [3:0] wrongPat);
        for (int e = 0; e <= lastM[k]; e++) begin
            if (e == wrongAt) begin
                modeQ.push_back('{k, 3'b111, scoreM[k], 1'b0, 1'b0, -1});
                pressStep(k, wrongPat);
                return;
            end
            if (e == lastM[k]) begin
                if (lastM[k] == depth - 1) begin
                    modeQ.push_back('{k, 3'b111, depth, 1'b1, 1'b0, -1});
                    scoreM[k] = depth;
                end else begin
                    modeQ.push_back('{k, 3'b001, scoreM[k] + 1, 1'b0, 1'b0, -1});
                end
            end
            pressStep(k, seqM[k][e]);
        end
        if (wrongAt < 0 && lastM[k] < depth - 1) begin
            scoreM[k]++;
            lastM[k]++;
        end
    endtask

    task automatic resetDut(input int k);
        modeQ.push_back('{k, 3'b001, 0, 1'b0, 1'b0, -1});
        @(posedge clk);
        #2;
        rstL[k] = 1'b0;
        #4;
        rstL[k] = 1'b1;
        lastM[k]  = 0;
        scoreM[k] = 0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rstL[k] = 1'b0; stepL[k] = 1'b0; patL[k] = 4'b0101;
            lastM[k] = 0; scoreM[k] = 0;
        end
        #23;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("dut%0d reset mode_leds", k), int'(modeA[k]), 1);
            checkOutput($sformatf("dut%0d reset score", k), int'(scoreA[k]), 0);
            checkOutput($sformatf("dut%0d reset win", k), int'(winA[k]), 0);
            checkOutput($sformatf("dut%0d reset timeout", k), int'(toA[k]), 0);
            checkOutput($sformatf("dut%0d reset mem_we", k), int'(weA[k]), 0);
            checkOutput($sformatf("dut%0d reset leds", k), int'(ledA[k]), 5);
        end
        for (int k = 0; k < 4; k++) rstL[k] = 1'b1;
        started = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] dut0: single round, then reset during playback");
        applyStimulus(0, 4'b0010);
        repeatRound(0, 64, -1, 4'b0000);
        seqM[0][1] = 4'b0001;
        wrQ.push_back('{0, 1, 4'b0001});
        modeQ.push_back('{0, 3'b010, 1, 1'b0, 1'b0, -1});
        ledQ.push_back('{0, 4'b0010});
        ledQ.push_back('{0, 4'b0010});
        modeQ.push_back('{0, 3'b001, 0, 1'b0, 1'b0, -1});
        pressStep(0, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        #2;
        rstL[0] = 1'b0;
        #1;
        checkOutput("dut0 async reset mode_leds", int'(modeA[0]), 1);
        checkOutput("dut0 async reset score", int'(scoreA[0]), 0);
        #4;
        rstL[0] = 1'b1;
        lastM[0] = 0;
        scoreM[0] = 0;

        $display("[TB] dut0: two rounds, then a wrong repeat");
        applyStimulus(0, 4'b0001);
        repeatRound(0, 64, -1, 4'b0000);
        applyStimulus(0, 4'b0100);
        repeatRound(0, 64, -1, 4'b0000);
        applyStimulus(0, 4'b1000);
        repeatRound(0, 64, 1, 4'b0010);
        pressStep(0, 4'b0001);
        pressStep(0, 4'b1000);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] dut1: one-hot legality");
        pressStep(1, 4'b0011);
        pressStep(1, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("dut1 illegal patterns keep INPUT", int'(modeA[1]), 1);
        applyStimulus(1, 4'b1000);
        repeatRound(1, 64, -1, 4'b0000);

        $display("[TB] dut2: fill a DEPTH=4 memory");
        applyStimulus(2, 4'b0001);
        repeatRound(2, 4, -1, 4'b0000);
        applyStimulus(2, 4'b0010);
        repeatRound(2, 4, -1, 4'b0000);
        applyStimulus(2, 4'b0100);
        repeatRound(2, 4, -1, 4'b0000);
        applyStimulus(2, 4'b1000);
        repeatRound(2, 4, -1, 4'b0000);
        pressStep(2, 4'b0001);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] dut3: repeat timeout and step priority");
        applyStimulus(3, 4'b0100);
        modeQ.push_back('{3, 3'b111, 0, 1'b0, 1'b1, 8});
        repeat (12) @(posedge clk);
        #1;
        pressStep(3, 4'b0100);
        repeat (2) @(posedge clk);
        resetDut(3);
        @(posedge clk);
        #1;
        applyStimulus(3, 4'b0001);
        modeQ.push_back('{3, 3'b001, 1, 1'b0, 1'b0, 8});
        repeat (7) @(posedge clk);
        #1;
        patL[3]  = 4'b0001;
        stepL[3] = 1'b1;
        @(posedge clk);
        #1;
        stepL[3] = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        checkOutput("pending mode events", modeQ.size(), 0);
        checkOutput("pending writes", wrQ.size(), 0);
        checkOutput("pending playback leds", ledQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
